// File: rtl/beacon_pkg.sv
// -----------------------------------------------------------------------------
// beacon_pkg
// Shared types and default timing constants for the sound beacon.
//   state_t    : sequencer state (IDLE, TONE, GAP)
//   DEF_*      : default timing for a 100 MHz clock and a 4 kHz tone
//   max_int    : larger of two integers (constant-expression helper)
//   cnt_width  : bits needed to count 0..n-1, never less than 1
// -----------------------------------------------------------------------------
package beacon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int DEF_HALF_PERIOD_CYC = 12500;  // 100 MHz / 2 / 4 kHz
   localparam int DEF_BURST_PERIODS   = 200;    // 50 ms of tone
   localparam int DEF_GAP_PERIODS     = 800;    // 200 ms of silence
   localparam int DEF_CNT_W           = 4;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tone_tick_gen.sv
// -----------------------------------------------------------------------------
// tone_tick_gen
// Free-running half-period counter. Emits a one-cycle tick every
// HALF_PERIOD_CYC cycles. A synchronous clear restarts the count so that the
// first tick after a clear lands exactly HALF_PERIOD_CYC cycles later.
// Ports:
//   clk    in  1  system clock
//   rst    in  1  synchronous active-high reset
//   clear  in  1  synchronous restart of the half-period count
//   tick   out 1  high for one cycle at the end of every half-period
// -----------------------------------------------------------------------------
module tone_tick_gen
   import beacon_pkg::*;
#(
   parameter int HALF_PERIOD_CYC = DEF_HALF_PERIOD_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int           W    = cnt_width(HALF_PERIOD_CYC);
   localparam logic [W-1:0] TERM = W'(HALF_PERIOD_CYC - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (cnt == TERM) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

   // Decoded from the counter register only, so the tick is glitch-free and
   // has no path from any module input.
   assign tick = (cnt == TERM);

endmodule

// File: rtl/sound_beacon.sv
// -----------------------------------------------------------------------------
// sound_beacon
// Drives a piezo/speaker pin with square-wave tone bursts separated by silent
// gaps, so that a peer robot's two-mic direction finder can localise us.
// A start request latches a burst count; count 0 means run until disabled.
// Ports:
//   clk          in  1      system clock
//   rst          in  1      synchronous active-high reset
//   enable       in  1      low forces idle and clears all counters
//   start        in  1      one-cycle request, honoured only when idle
//   burst_count  in  CNT_W  number of bursts (0 = continuous)
//   speaker      out 1      square-wave tone output
//   busy         out 1      high while a sequence is running
//   done         out 1      one-cycle pulse when a finite sequence completes
//   led          out 1      copy of busy
// -----------------------------------------------------------------------------
module sound_beacon
   import beacon_pkg::*;
#(
   parameter int HALF_PERIOD_CYC = DEF_HALF_PERIOD_CYC,
   parameter int BURST_PERIODS   = DEF_BURST_PERIODS,
   parameter int GAP_PERIODS     = DEF_GAP_PERIODS,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_count,
   output logic             speaker,
   output logic             busy,
   output logic             done,
   output logic             led
);

   // The toggle counter counts half-periods inside a burst or a gap.
   localparam int               TOG_W     = cnt_width(2 * max_int(BURST_PERIODS, GAP_PERIODS));
   localparam logic [TOG_W-1:0] TONE_LAST = TOG_W'(2 * BURST_PERIODS - 1);
   localparam logic [TOG_W-1:0] GAP_LAST  = TOG_W'(2 * GAP_PERIODS - 1);

   state_t           state;
   logic [TOG_W-1:0] tog;
   logic [CNT_W-1:0] remaining;
   logic             tick;
   logic             accept;
   logic             tick_clear;

   assign accept     = (state == IDLE) && enable && start;
   // Restarting the half-period counter on acceptance aligns the first
   // toggle to exactly HALF_PERIOD_CYC cycles after the start edge.
   assign tick_clear = accept || !enable;

   tone_tick_gen #(
      .HALF_PERIOD_CYC (HALF_PERIOD_CYC)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         state     <= IDLE;
         speaker   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tog       <= '0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= TONE;
                  speaker   <= 1'b1;
                  busy      <= 1'b1;
                  tog       <= '0;
                  remaining <= burst_count;
               end
            end

            TONE: begin
               if (tick) begin
                  if (tog == TONE_LAST) begin
                     // Burst complete; the last half-period was already low.
                     tog     <= '0;
                     speaker <= 1'b0;
                     if (remaining == '0) begin
                        // A latched count of 0 can only be seen here in
                        // continuous mode: finite runs leave TONE at 1.
                        state <= GAP;
                     end else if (remaining == CNT_W'(1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        remaining <= '0;
                     end else begin
                        remaining <= remaining - CNT_W'(1);
                        state     <= GAP;
                     end
                  end else begin
                     tog     <= tog + TOG_W'(1);
                     speaker <= ~speaker;
                  end
               end
            end

            GAP: begin
               if (tick) begin
                  if (tog == GAP_LAST) begin
                     tog     <= '0;
                     speaker <= 1'b1;
                     state   <= TONE;
                  end else begin
                     tog <= tog + TOG_W'(1);
                  end
               end
            end

            default: begin
               state   <= IDLE;
               speaker <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   assign led = busy;

endmodule

// File: tb/tb_sound_beacon.sv
module tb_sound_beacon;

   localparam int H   = 4;
   localparam int BP  = 3;
   localparam int GP  = 2;
   localparam int CW  = 4;
   localparam int B   = 2 * BP * H;   // tone burst length in cycles (24)
   localparam int G   = 2 * GP * H;   // gap length in cycles (16)
   localparam int PER = B + G;        // 40

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          start;
   logic [CW-1:0] burst_count;
   logic          speaker;
   logic          busy;
   logic          done;
   logic          led;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int done_cnt = 0;

   sound_beacon #(
      .HALF_PERIOD_CYC (H),
      .BURST_PERIODS   (BP),
      .GAP_PERIODS     (GP),
      .CNT_W           (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .start       (start),
      .burst_count (burst_count),
      .speaker     (speaker),
      .busy        (busy),
      .done        (done),
      .led         (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model: time elapsed since the accepted start decides all
   // outputs. Cycle k=1 is the first cycle after the accepting edge.
   // ---------------------------------------------------------------------
   bit   m_act = 1'b0;
   int   m_k   = 0;
   int   m_n   = 0;
   logic e_spk = 1'b0, e_busy = 1'b0, e_done = 1'b0;
   bit   model_ok = 1'b0;

   function automatic int seq_len(input int n);
      return n * B + (n - 1) * G;
   endfunction

   always @(posedge clk) begin
      bit idle_now;
      int p;
      cyc++;
      if (done === 1'b1) done_cnt++;
      idle_now = !m_act || (m_n != 0 && m_k > seq_len(m_n));
      if (rst || !enable) begin
         m_act = 1'b0;
      end else if (idle_now && start) begin
         m_act = 1'b1;
         m_k   = 1;
         m_n   = int'(burst_count);
      end else if (idle_now) begin
         m_act = 1'b0;
      end else begin
         m_k++;
      end
      e_spk  = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (m_act) begin
         if (m_n == 0 || m_k <= seq_len(m_n)) begin
            e_busy = 1'b1;
            p      = (m_k - 1) % PER;
            e_spk  = (p < B) && (((p / H) % 2) == 0);
         end else begin
            e_done = 1'b1;
         end
      end
      model_ok = 1'b1;
   end

   // Every cycle: DUT against model, sampled mid-cycle.
   always @(negedge clk) begin
      if (model_ok) begin
         check("model_speaker", speaker, e_spk);
         check("model_busy",    busy,    e_busy);
         check("model_done",    done,    e_done);
         check("model_led",     led,     e_busy);
      end
   end

   task automatic skip(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives start for one edge; returns in the first cycle after acceptance.
   task automatic start_seq(input int n);
      start       = 1'b1;
      burst_count = CW'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int d0;
      rst         = 1'b1;
      enable      = 1'b1;
      start       = 1'b1;
      burst_count = CW'(1);

      // Reset held 3 cycles with start asserted: everything stays low.
      repeat (3) begin
         @(negedge clk);
         check("rst_speaker", speaker, 1'b0);
         check("rst_busy",    busy,    1'b0);
         check("rst_done",    done,    1'b0);
         check("rst_led",     led,     1'b0);
      end
      rst   = 1'b0;
      start = 1'b0;
      skip(2);
      check("post_rst_busy", busy, 1'b0);

      // Single burst, then a start on the done cycle.
      start_seq(1);
      check("c1_spk_t1",   speaker, 1'b1);
      check("c1_busy_t1",  busy,    1'b1);
      skip(3);
      check("c1_spk_t4",   speaker, 1'b1);
      skip(1);
      check("c1_spk_t5",   speaker, 1'b0);
      skip(19);
      check("c1_busy_t24", busy,    1'b1);
      check("c1_done_t24", done,    1'b0);
      skip(1);
      check("c1_done_t25", done,    1'b1);
      check("c1_busy_t25", busy,    1'b0);
      start_seq(1);
      check("c1b_spk_t1",  speaker, 1'b1);
      check("c1b_done_t1", done,    1'b0);
      skip(24);
      check("c1b_done_t25", done,   1'b1);
      skip(1);
      check("c1b_done_t26", done,   1'b0);
      skip(2);

      // Two bursts with one gap.
      start_seq(2);
      skip(24);
      check("c2_gap_spk_t25",  speaker, 1'b0);
      check("c2_gap_busy_t25", busy,    1'b1);
      skip(16);
      check("c2_spk_t41",  speaker, 1'b1);
      skip(23);
      check("c2_busy_t64", busy,    1'b1);
      skip(1);
      check("c2_done_t65", done,    1'b1);
      skip(2);

      // Continuous mode for five full periods, then disable.
      d0 = done_cnt;
      start_seq(0);
      skip(200);
      check("cont_spk_t201",  speaker, 1'b1);
      check("cont_busy_t201", busy,    1'b1);
      check_int("cont_no_done", done_cnt, d0);
      enable = 1'b0;
      @(negedge clk);
      check("dis_spk",  speaker, 1'b0);
      check("dis_busy", busy,    1'b0);
      check("dis_done", done,    1'b0);
      enable = 1'b1;
      skip(2);

      // Second start while busy has no effect.
      start_seq(1);
      skip(9);
      start       = 1'b1;
      burst_count = CW'(3);
      @(negedge clk);
      start = 1'b0;
      skip(13);
      check("ign_busy_t24", busy, 1'b1);
      skip(1);
      check("ign_done_t25", done, 1'b1);
      skip(2);

      // Enable dropped mid-gap, then a clean fresh burst.
      d0 = done_cnt;
      start_seq(2);
      skip(29);
      check("ab_gap_spk", speaker, 1'b0);
      check("ab_gap_busy", busy,   1'b1);
      enable = 1'b0;
      @(negedge clk);
      check("ab_busy", busy, 1'b0);
      skip(3);
      enable = 1'b1;
      skip(2);
      start_seq(1);
      check("fresh_spk_t1", speaker, 1'b1);
      skip(23);
      check("fresh_busy_t24", busy, 1'b1);
      skip(1);
      check("fresh_done_t25", done, 1'b1);
      check_int("ab_no_done", done_cnt, d0);
      skip(2);

      // Reset in the middle of a burst.
      start_seq(1);
      skip(5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_spk",  speaker, 1'b0);
      check("mid_rst_busy", busy,    1'b0);
      skip(30);
      check("mid_rst_no_done", done, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
